// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_serializer parallel-in/serial-out transmitter.
`timescale 1ns/1ps
package piso_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial-line bundle between a word source and piso_serializer.
`timescale 1ns/1ps
interface piso_serializer_if #(parameter int WIDTH = 4) ();
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pdata;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, pdata,
        input  load_ready, sout, sout_valid, frame_start, busy, done
    );

    modport slave (
        input  load_valid, pdata,
        output load_ready, sout, sout_valid, frame_start, busy, done
    );
endinterface

// File: rtl/piso_bit_counter.sv
// Index of the frame bit currently on the serial line; flags the last and next-to-last data bits.
`timescale 1ns/1ps
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_CNT = WIDTH - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last_data,
    output logic pre_last
);
    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] cnt_r;

    // Clear wins over increment; the count saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc && (cnt_r != CW'(MAX_CNT))) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign last_data = (cnt_r == CW'(WIDTH - 1));
    assign pre_last  = (cnt_r == CW'(WIDTH - 2));
endmodule

// File: rtl/piso_serializer.sv
// MSB-first serializer with valid/ready load and back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
`timescale 1ns/1ps
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic             clk,
    input logic             rst,
    piso_serializer_if.slave bus
);
`ifdef PISO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    state_t           state_r;
    logic [WIDTH-2:0] sr_r;
    logic             sout_r;
    logic             sout_valid_r;
    logic             frame_start_r;
    logic             done_r;
    logic             busy_r;
`ifdef PISO_PARITY_EN
    logic             par_r;
`endif
    logic             ready_s;
    logic             hs_s;
    logic             last_s;
    logic             pre_last_s;

    // Accept a word when idle or while the final bit of the current frame is on the line.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            S_IDLE:   ready_s = 1'b1;
            S_SHIFT:  ready_s = last_s && !PAR_EN;
            S_PARITY: ready_s = 1'b1;
            default:  ready_s = 1'b0;
        endcase
    end

    assign hs_s = bus.load_valid && ready_s;

    piso_bit_counter #(
        .WIDTH   (WIDTH),
        .MAX_CNT (PAR_EN ? WIDTH : WIDTH - 1)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (ready_s),
        .inc       (state_r == S_SHIFT),
        .last_data (last_s),
        .pre_last  (pre_last_s)
    );

    // FSM, shift register and registered line outputs; sr_r holds the bits still to be sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            sr_r          <= {(WIDTH-1){1'b0}};
            sout_r        <= IDLE_LEVEL;
            sout_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
`ifdef PISO_PARITY_EN
            par_r         <= 1'b0;
`endif
        end else if (hs_s) begin
            state_r       <= S_SHIFT;
            sr_r          <= bus.pdata[WIDTH-2:0];
            sout_r        <= bus.pdata[WIDTH-1];
            sout_valid_r  <= 1'b1;
            frame_start_r <= 1'b1;
            done_r        <= 1'b0;
            busy_r        <= 1'b1;
`ifdef PISO_PARITY_EN
            par_r         <= even_parity(64'(bus.pdata));
`endif
        end else begin
            case (state_r)
                S_SHIFT: begin
                    if (!last_s) begin
                        sout_r        <= sr_r[WIDTH-2];
                        sr_r          <= sr_r << 1'b1;
                        frame_start_r <= 1'b0;
                        done_r        <= pre_last_s && !PAR_EN;
                    end else begin
`ifdef PISO_PARITY_EN
                        state_r       <= S_PARITY;
                        sout_r        <= par_r;
                        frame_start_r <= 1'b0;
                        done_r        <= 1'b1;
`else
                        state_r       <= S_IDLE;
                        sout_r        <= IDLE_LEVEL;
                        sout_valid_r  <= 1'b0;
                        frame_start_r <= 1'b0;
                        done_r        <= 1'b0;
                        busy_r        <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r       <= S_IDLE;
                    sout_r        <= IDLE_LEVEL;
                    sout_valid_r  <= 1'b0;
                    frame_start_r <= 1'b0;
                    done_r        <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready  = ready_s;
    assign bus.sout        = sout_r;
    assign bus.sout_valid  = sout_valid_r;
    assign bus.frame_start = frame_start_r;
    assign bus.done        = done_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: accepted words become expected bit streams checked by a monitor.
`timescale 1ns/1ps
module tb_piso_serializer;
    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic         b;
        logic         fs;
        logic         dn;
        logic         dat;
        logic [W-1:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mon_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    logic [W-1:0] sipo = '0;
    int   sipo_n = 0;

    piso_serializer_if #(.WIDTH(W)) bus ();

    piso_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // A frame is the word's bits MSB first, optionally followed by its even parity.
    task automatic push_frame(input logic [W-1:0] w);
        exp_t e;
        for (int k = 0; k < W; k++) begin
            e.b    = w[W-1-k];
            e.fs   = (k == 0);
            e.dn   = (k == W - 1) && !PAR;
            e.dat  = 1'b1;
            e.word = w;
            exp_q.push_back(e);
        end
        if (PAR) begin
            e.b    = ^w;
            e.fs   = 1'b0;
            e.dn   = 1'b1;
            e.dat  = 1'b0;
            e.word = w;
            exp_q.push_back(e);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic send(input logic [W-1:0] w);
        bit   acc;
        logic rdy;
        acc = 1'b0;
        bus.load_valid = 1'b1;
        bus.pdata      = w;
        for (int n = 0; n < 50 && !acc; n++) begin
            rdy = bus.load_ready;
            @(posedge clk);
            if (rdy) begin
                push_frame(w);
                acc = 1'b1;
            end
            @(negedge clk);
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: word %0h not accepted within 50 cycles", w);
        end
        bus.load_valid = 1'b0;
        bus.pdata      = W'($urandom);
    endtask

    task automatic wait_idle();
        bit drained;
        drained = 1'b0;
        for (int n = 0; n < 40 && !drained; n++) begin
            if (exp_q.size() == 0 && !bus.sout_valid) drained = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!drained) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d bits still expected", exp_q.size());
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.sout_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_bit: sout_valid=1 but no bit expected at %0t", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sout", 32'(bus.sout), 32'(e.b));
                    chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
                    chk("done", 32'(bus.done), 32'(e.dn));
                    chk("load_ready_frame", 32'(bus.load_ready), 32'(e.dn));
                    chk("busy_frame", 32'(bus.busy), 32'd1);
                    if (e.fs) sipo_n = 0;
                    if (e.dat) begin
                        sipo = {sipo[W-2:0], bus.sout};
                        sipo_n++;
                        if (sipo_n == W) chk("sipo_word", 32'(sipo), 32'(e.word));
                    end
                end
            end else begin
                chk("idle_sout", 32'(bus.sout), 32'd0);
                chk("idle_done", 32'(bus.done), 32'd0);
                chk("idle_frame_start", 32'(bus.frame_start), 32'd0);
                chk("idle_busy", 32'(bus.busy), 32'd0);
                chk("idle_load_ready", 32'(bus.load_ready), 32'd1);
                chk("no_gap", 32'(exp_q.size()), 32'd0);
            end
        end
    end

    initial begin
        logic [W-1:0] w;
        int gap;
        bus.load_valid = 1'b0;
        bus.pdata      = '0;
        rst = 1'b1;
        #10;
        rst = 1'b0;
        #1;
        chk("rst_sout", 32'(bus.sout), 32'd0);
        chk("rst_sout_valid", 32'(bus.sout_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
        mon_en = 1'b1;
        @(negedge clk);

        send(4'b1011);
        wait_idle();

        send(4'b1011);
        send(4'b0110);
        wait_idle();

        // 4'b1111 is offered while 4'b1000 is mid-frame and must wait for its last bit.
        send(4'b1000);
        @(negedge clk);
        send(4'b1111);
        wait_idle();

        // Abort 4'b1101 after its second bit.
        send(4'b1101);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_sout_valid", 32'(bus.sout_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_sout", 32'(bus.sout), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        exp_q.delete();
        sipo_n = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(4'b0011);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            w   = W'($urandom);
            gap = $urandom_range(0, 3);
            send(w);
            repeat (gap) @(negedge clk);
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
